// File: rtl/control_unit.sv
// control_unit: registered MIPS main decoder, opcode -> strobes and ALUOp.
// Optional CTRL_JUMP_EN adds a registered 2-bit jump output.
module control_unit #(
  parameter int NUM_SIGNALS = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             ins,
  output logic [NUM_SIGNALS-1:0] signals,
  output logic [2:0]             ALUOp
`ifdef CTRL_JUMP_EN
  ,
  output logic [1:0]             jump
`endif
);

  localparam int REGDST   = 0;
  localparam int BRANCH   = 1;
  localparam int MEMREAD  = 2;
  localparam int MEMTOREG = 3;
  localparam int MEMWRITE = 4;
  localparam int ALUSRC   = 5;
  localparam int REGWRITE = 6;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_FUNC = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_LUI  = 3'b111;

  logic [NUM_SIGNALS-1:0] sig_d;
  logic [2:0]             alu_d;
`ifdef CTRL_JUMP_EN
  logic [1:0]             jmp_d;
`endif

  always_comb begin
    sig_d = '0;
    alu_d = ALU_ADD;
`ifdef CTRL_JUMP_EN
    jmp_d = 2'b00;
`endif
    unique case (ins)
      6'b000000: begin
        sig_d[REGDST]   = 1'b1;
        sig_d[REGWRITE] = 1'b1;
        alu_d           = ALU_FUNC;
      end
      6'b100011, 6'b100100, 6'b100101: begin
        sig_d[MEMREAD]  = 1'b1;
        sig_d[MEMTOREG] = 1'b1;
        sig_d[ALUSRC]   = 1'b1;
        sig_d[REGWRITE] = 1'b1;
      end
      6'b101011, 6'b101000, 6'b101001: begin
        sig_d[MEMWRITE] = 1'b1;
        sig_d[ALUSRC]   = 1'b1;
      end
      // bne vs beq is resolved from ins[0] in the branch logic
      6'b000100, 6'b000101: begin
        sig_d[BRANCH] = 1'b1;
        alu_d         = ALU_SUB;
      end
      6'b001000, 6'b001001: begin
        sig_d[ALUSRC]   = 1'b1;
        sig_d[REGWRITE] = 1'b1;
      end
      6'b001100: begin
        sig_d[ALUSRC]   = 1'b1;
        sig_d[REGWRITE] = 1'b1;
        alu_d           = ALU_AND;
      end
      6'b001101: begin
        sig_d[ALUSRC]   = 1'b1;
        sig_d[REGWRITE] = 1'b1;
        alu_d           = ALU_OR;
      end
      6'b001010: begin
        sig_d[ALUSRC]   = 1'b1;
        sig_d[REGWRITE] = 1'b1;
        alu_d           = ALU_SLT;
      end
      6'b001011: begin
        sig_d[ALUSRC]   = 1'b1;
        sig_d[REGWRITE] = 1'b1;
        alu_d           = ALU_SLTU;
      end
      6'b001111: begin
        sig_d[ALUSRC]   = 1'b1;
        sig_d[REGWRITE] = 1'b1;
        alu_d           = ALU_LUI;
      end
`ifdef CTRL_JUMP_EN
      6'b000010: begin
        jmp_d = 2'b01;
      end
      // jal writes the return address to $ra
      6'b000011: begin
        sig_d[REGWRITE] = 1'b1;
        jmp_d           = 2'b10;
      end
`endif
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      signals <= '0;
      ALUOp   <= 3'b000;
`ifdef CTRL_JUMP_EN
      jump    <= 2'b00;
`endif
    end else begin
      signals <= sig_d;
      ALUOp   <= alu_d;
`ifdef CTRL_JUMP_EN
      jump    <= jmp_d;
`endif
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed + random opcode checks against a table model.
// Honours CTRL_JUMP_EN to exercise the optional jump output.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] ins = 6'd0;
  logic [6:0] signals;
  logic [2:0] ALUOp;
`ifdef CTRL_JUMP_EN
  logic [1:0] jump;
`endif

  int tests = 0;
  int fails = 0;

  logic [6:0] m_sig [64];
  logic [2:0] m_alu [64];
  logic [1:0] m_jmp [64];

  logic [6:0] e_sig;
  logic [2:0] e_alu;
  logic [1:0] e_jmp;
  bit         known = 1'b0;

  control_unit #(.NUM_SIGNALS(7)) dut (
    .clk     (clk),
    .rst     (rst),
    .ins     (ins),
    .signals (signals),
    .ALUOp   (ALUOp)
`ifdef CTRL_JUMP_EN
    ,
    .jump    (jump)
`endif
  );

  always #5 clk = ~clk;

  task automatic put(input int op, input int s, input int a, input int j);
    m_sig[op] = 7'(s);
    m_alu[op] = 3'(a);
    m_jmp[op] = 2'(j);
  endtask

  task automatic build_model();
    for (int i = 0; i < 64; i++) put(i, 0, 0, 0);
    put(6'b000000, 'h41, 2, 0);
    put(6'b100011, 'h6C, 0, 0);
    put(6'b100100, 'h6C, 0, 0);
    put(6'b100101, 'h6C, 0, 0);
    put(6'b101011, 'h30, 0, 0);
    put(6'b101000, 'h30, 0, 0);
    put(6'b101001, 'h30, 0, 0);
    put(6'b000100, 'h02, 1, 0);
    put(6'b000101, 'h02, 1, 0);
    put(6'b001000, 'h60, 0, 0);
    put(6'b001001, 'h60, 0, 0);
    put(6'b001100, 'h60, 3, 0);
    put(6'b001101, 'h60, 4, 0);
    put(6'b001010, 'h60, 5, 0);
    put(6'b001011, 'h60, 6, 0);
    put(6'b001111, 'h60, 7, 0);
`ifdef CTRL_JUMP_EN
    put(6'b000010, 'h00, 0, 1);
    put(6'b000011, 'h40, 0, 2);
`endif
  endtask

  task automatic check(input string tag);
    tests++;
    assert (signals === e_sig) else begin
      fails++;
      $error("FAIL %s signals got %h exp %h", tag, signals, e_sig);
    end
    tests++;
    assert (ALUOp === e_alu) else begin
      fails++;
      $error("FAIL %s ALUOp got %b exp %b", tag, ALUOp, e_alu);
    end
`ifdef CTRL_JUMP_EN
    tests++;
    assert (jump === e_jmp) else begin
      fails++;
      $error("FAIL %s jump got %b exp %b", tag, jump, e_jmp);
    end
`endif
  endtask

  task automatic step(input logic [5:0] op, input logic r, input string tag);
    @(negedge clk);
    ins = op;
    rst = r;
    #1;
    if (known) check({tag, "_hold"});
    @(posedge clk);
    #1;
    if (r) begin
      e_sig = 7'h00;
      e_alu = 3'b000;
      e_jmp = 2'b00;
    end else begin
      e_sig = m_sig[op];
      e_alu = m_alu[op];
      e_jmp = m_jmp[op];
    end
    check(tag);
    known = 1'b1;
  endtask

  initial begin
    logic [5:0] op;
    logic       r;
    build_model();
    step(6'b000000, 1'b1, "rst1");
    step(6'b000000, 1'b1, "rst2");
    step(6'b000000, 1'b0, "rtype");
    step(6'b100011, 1'b0, "lw");
    step(6'b101011, 1'b0, "sw");
    step(6'b000100, 1'b0, "beq");
    step(6'b000101, 1'b0, "bne");
    step(6'b001100, 1'b0, "andi");
    step(6'b001101, 1'b0, "ori");
    step(6'b001010, 1'b0, "slti");
    step(6'b001011, 1'b0, "sltiu");
    step(6'b001000, 1'b0, "addi");
    step(6'b001111, 1'b0, "lui");
    step(6'b100111, 1'b0, "illegal");
    step(6'b000010, 1'b0, "j");
    step(6'b000011, 1'b0, "jal");
    step(6'b001101, 1'b0, "ori_pre");
    step(6'b001101, 1'b1, "ori_rst");
    step(6'b001101, 1'b0, "ori_post");
    for (int i = 0; i < 64; i++) begin
      op = 6'(i);
      step(op, 1'b0, "sweep");
    end
    for (int i = 0; i < 300; i++) begin
      op = 6'($urandom_range(0, 63));
      r  = ($urandom_range(0, 9) == 0);
      step(op, r, "rand");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
